// File: rtl/dm_byte_sequencer.sv
// Data-memory byte sequencer: splits b/h/w loads and stores into little-endian
// byte transactions on a byte-wide bus and returns one response per request.
module dm_byte_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              DMWr,
    input  logic [2:0]        DMCtrl,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WrData,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       RdData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q;
    logic              we_q;
    logic [2:0]        ctrl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        k_q;
    logic [1:0]        last_q;
    logic [WW-1:0]     wait_q;
    logic [31:0]       rbuf_q;

    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rddata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic              illegal_d;
    logic              misalign_d;
    logic [1:0]        last_d;
    logic [1:0]        kn_d;
    logic [31:0]       rbuf_d;
    logic [31:0]       result_d;
    logic              timeout_hit;

    always_comb begin
        illegal_d  = (DMCtrl == 3'b011) || (DMCtrl[2:1] == 2'b11) || (DMWr && DMCtrl[2]);
        misalign_d = ((DMCtrl[1:0] == 2'b01) && Addr[0]) ||
                     ((DMCtrl[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
        case (DMCtrl[1:0])
            2'b00:   last_d = 2'd0;
            2'b01:   last_d = 2'd1;
            default: last_d = 2'd3;
        endcase
        kn_d = k_q + 2'd1;
    end

    // Merge the byte arriving this edge so the final byte feeds the result directly.
    always_comb begin
        rbuf_d = rbuf_q;
        rbuf_d[{k_q, 3'b000} +: 8] = mem_rdata;
        case (ctrl_q)
            3'b000:  result_d = {{24{rbuf_d[7]}}, rbuf_d[7:0]};
            3'b100:  result_d = {24'd0, rbuf_d[7:0]};
            3'b001:  result_d = {{16{rbuf_d[15]}}, rbuf_d[15:0]};
            3'b101:  result_d = {16'd0, rbuf_d[15:0]};
            default: result_d = rbuf_d;
        endcase
        timeout_hit = (TIMEOUT != 0) && ((32'(wait_q) + 32'd1) == TIMEOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            ctrl_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            k_q         <= '0;
            last_q      <= '0;
            wait_q      <= '0;
            rbuf_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rddata_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= DMWr;
                        ctrl_q  <= DMCtrl;
                        addr_q  <= Addr;
                        wdata_q <= WrData;
                        last_q  <= last_d;
                        k_q     <= '0;
                        wait_q  <= '0;
                        rbuf_q  <= '0;
                        if (illegal_d || misalign_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rddata_q    <= '0;
                        end else begin
                            state_q     <= ACCESS;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= DMWr;
                            mem_addr_q  <= Addr;
                            mem_wdata_q <= WrData[7:0];
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        wait_q <= '0;
                        if (!we_q) rbuf_q <= rbuf_d;
                        if (k_q == last_q) begin
                            state_q     <= RESP;
                            mem_req_q   <= 1'b0;
                            mem_we_q    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rddata_q    <= we_q ? '0 : result_d;
                        end else begin
                            k_q         <= kn_d;
                            mem_addr_q  <= addr_q + ADDR_W'(kn_d);
                            mem_wdata_q <= wdata_q[{kn_d, 3'b000} +: 8];
                        end
                    end else begin
                        wait_q <= wait_q + 1'b1;
                        if (timeout_hit) begin
                            state_q     <= RESP;
                            mem_req_q   <= 1'b0;
                            mem_we_q    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rddata_q    <= '0;
                        end
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign RdData    = rddata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dm_byte_sequencer.sv
// Bench for dm_byte_sequencer: byte-memory responder with per-byte wait control
// and a reference model that computes load results by arithmetic on bytes.
module tb_dm_byte_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          DMWr;
    logic [2:0]    DMCtrl;
    logic [AW-1:0] Addr;
    logic [31:0]   WrData;
    logic          rsp_valid;
    logic          rsp_err;
    logic [31:0]   RdData;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_ack;
    logic [7:0]    mem_rdata;

    dm_byte_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .DMWr(DMWr), .DMCtrl(DMCtrl), .Addr(Addr), .WrData(WrData),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .RdData(RdData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:4095];
    int          waits[$];
    bit          never_ack = 1'b0;
    int          req_cycles = 0;
    int          cnt = 0;
    logic [31:0] log_addr[$];
    logic        log_we[$];
    logic [7:0]  log_wd[$];

    // Byte-memory responder: acks after the queued number of wait cycles per byte.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                req_cycles++;
                if (!never_ack && cnt >= ((waits.size() > 0) ? waits[0] : 0)) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_we ? 8'($urandom) : mem[mem_addr[11:0]];
                    log_addr.push_back(mem_addr);
                    log_we.push_back(mem_we);
                    log_wd.push_back(mem_wdata);
                    if (mem_we) mem[mem_addr[11:0]] = mem_wdata;
                    if (waits.size() > 0) void'(waits.pop_front());
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                  output logic err, output logic [31:0] rd, output int n);
        bit     sgn;
        longint v;
        logic [31:0] a;
        sgn = 1'b0;
        case (ctrl)
            3'b000: begin n = 1; sgn = 1'b1; end
            3'b001: begin n = 2; sgn = 1'b1; end
            3'b010: n = 4;
            3'b100: n = 1;
            3'b101: n = 2;
            default: n = 0;
        endcase
        if (n == 0) err = 1'b1;
        else err = (we && (ctrl == 3'b100 || ctrl == 3'b101)) || ((addr % n) != 0);
        rd = '0;
        if (!err && !we) begin
            v = 0;
            for (int i = 0; i < n; i++) begin
                a = addr + i;
                v += longint'(mem[a[11:0]]) << (8 * i);
            end
            if (sgn && v >= (64'd1 << (8 * n - 1))) v -= (64'd1 << (8 * n));
            rd = v[31:0];
        end
        if (err) n = 0;
    endfunction

    task automatic run_req(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                           output logic err, output logic ready_resp, output logic ready_after,
                           output logic valid_after);
        int g;
        lat = -1; rd = '0; err = 1'b0; ready_resp = 1'b1; ready_after = 1'b0; valid_after = 1'b1;
        @(negedge clk);
        log_addr.delete(); log_we.delete(); log_wd.delete();
        req_cycles = 0;
        g = 0;
        while (!req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        req_valid = 1'b1; DMWr = we; DMCtrl = ctrl; Addr = addr; WrData = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c; rd = RdData; err = rsp_err; ready_resp = req_ready;
                break;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            ready_after = req_ready;
            valid_after = rsp_valid;
        end
        waits.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; DMWr = 1'b0; DMCtrl = '0; Addr = '0; WrData = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rsp_valid, rsp_err, mem_req, mem_we, mem_addr, mem_wdata, RdData} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rv=%b re=%b mr=%b mw=%b ma=%h md=%h rd=%h, want all 0",
                     rsp_valid, rsp_err, mem_req, mem_we, mem_addr, mem_wdata, RdData);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_byte_load();
        int lat; logic [31:0] rd; logic err, rr, ra, va;
        logic [31:0] exp_rd [2];
        exp_rd[0] = 32'hFFFFFF80; exp_rd[1] = 32'h00000080;
        mem[12'h103] = 8'h80;
        for (int t = 0; t < 2; t++) begin
            run_req(1'b0, (t == 0) ? 3'b000 : 3'b100, 32'h103, $urandom, lat, rd, err, rr, ra, va);
            total++;
            if (rd !== exp_rd[t]) begin bad++; $display("FAIL byte_load_rd[%0d]: got %h want %h", t, rd, exp_rd[t]); end
            total++;
            if ({err, lat} !== {1'b0, 32'd2}) begin bad++; $display("FAIL byte_load_lat[%0d]: got err=%b lat=%0d want err=0 lat=2", t, err, lat); end
            total++;
            if (log_addr.size() != 1 || req_cycles != 1 || log_addr[0] !== 32'h103) begin
                bad++; $display("FAIL byte_load_bus[%0d]: got %0d acks %0d req cycles, want 1 at 103", t, log_addr.size(), req_cycles);
            end
        end
    endtask

    task automatic test_word_load();
        int lat; logic [31:0] rd; logic err, rr, ra, va;
        mem[12'h200] = 8'h11; mem[12'h201] = 8'h22; mem[12'h202] = 8'h33; mem[12'h203] = 8'h44;
        run_req(1'b0, 3'b010, 32'h200, 32'h0, lat, rd, err, rr, ra, va);
        total++;
        if (rd !== 32'h44332211) begin bad++; $display("FAIL word_load_rd: got %h want 44332211", rd); end
        total++;
        if (lat != 5 || err !== 1'b0) begin bad++; $display("FAIL word_load_lat: got lat=%0d err=%b want 5 0", lat, err); end
        total++;
        if (log_addr.size() != 4) begin bad++; $display("FAIL word_load_count: got %0d want 4", log_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++;
            if (log_addr[i] !== 32'h200 + i) begin bad++; $display("FAIL word_load_addr[%0d]: got %h want %h", i, log_addr[i], 32'h200 + i); end
        end
        total++;
        if (rr !== 1'b0 || ra !== 1'b1 || va !== 1'b0) begin
            bad++; $display("FAIL word_load_handshake: got ready_in_resp=%b ready_after=%b valid_after=%b want 0 1 0", rr, ra, va);
        end
    endtask

    task automatic test_store_waits();
        int lat; logic [31:0] rd; logic err, rr, ra, va;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hD4; exp_b[1] = 8'hC3; exp_b[2] = 8'hB2; exp_b[3] = 8'hA1;
        waits = '{2, 2, 2, 2};
        run_req(1'b1, 3'b010, 32'h300, 32'hA1B2C3D4, lat, rd, err, rr, ra, va);
        total++;
        if (lat != 13 || err !== 1'b0 || rd !== 32'h0) begin
            bad++; $display("FAIL store_resp: got lat=%0d err=%b rd=%h want 13 0 0", lat, err, rd);
        end
        total++;
        if (log_addr.size() != 4) begin bad++; $display("FAIL store_count: got %0d want 4", log_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++;
            if ({log_addr[i], log_we[i], log_wd[i]} !== {32'h300 + i, 1'b1, exp_b[i]}) begin
                bad++; $display("FAIL store_byte[%0d]: got a=%h we=%b d=%h want a=%h we=1 d=%h",
                                i, log_addr[i], log_we[i], log_wd[i], 32'h300 + i, exp_b[i]);
            end
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic err, rr, ra, va;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) run_req(1'b1, 3'b001, 32'h201, $urandom, lat, rd, err, rr, ra, va);
            else        run_req(1'b0, 3'b011, 32'h0, $urandom, lat, rd, err, rr, ra, va);
            total++;
            if (lat != 1 || err !== 1'b1 || rd !== 32'h0) begin
                bad++; $display("FAIL error_resp[%0d]: got lat=%0d err=%b rd=%h want 1 1 0", t, lat, err, rd);
            end
            total++;
            if (req_cycles != 0 || ra !== 1'b1 || va !== 1'b0) begin
                bad++; $display("FAIL error_bus[%0d]: got req_cycles=%0d ready2=%b valid2=%b want 0 1 0", t, req_cycles, ra, va);
            end
        end
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd; logic err, rr, ra, va;
        mem[12'h050] = 8'hA5;
        run_req(1'b0, 3'b000, 32'h50, 32'h0, lat, rd, err, rr, ra, va);
        total++;
        if (rd !== 32'hFFFFFFA5) begin bad++; $display("FAIL timeout_pre_rd: got %h want ffffffa5", rd); end
        never_ack = 1'b1;
        run_req(1'b0, 3'b001, 32'h10, 32'h0, lat, rd, err, rr, ra, va);
        never_ack = 1'b0;
        total++;
        if (req_cycles != TO || lat != TO + 1) begin
            bad++; $display("FAIL timeout_len: got req_cycles=%0d lat=%0d want %0d %0d", req_cycles, lat, TO, TO + 1);
        end
        total++;
        if (err !== 1'b1 || rd !== 32'h0 || ra !== 1'b1) begin
            bad++; $display("FAIL timeout_resp: got err=%b rd=%h ready_after=%b want 1 0 1", err, rd, ra);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic err, rr, ra, va;
        logic we; logic [2:0] ctrl; logic [31:0] addr, wdata, exp_rd, a;
        logic exp_err; int n, exp_lat;
        int w [4];
        for (int it = 0; it < 60; it++) begin
            we = 1'($urandom_range(0, 1));
            ctrl = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            wdata = $urandom;
            model(we, ctrl, addr, exp_err, exp_rd, n);
            exp_lat = 1;
            for (int i = 0; i < 4; i++) begin
                w[i] = $urandom_range(0, TO - 1);
                waits.push_back(w[i]);
                if (i < n) exp_lat += w[i] + 1;
            end
            run_req(we, ctrl, addr, wdata, lat, rd, err, rr, ra, va);
            total++;
            if ({err, rd} !== {exp_err, exp_rd} || lat != exp_lat) begin
                bad++; $display("FAIL random[%0d] we=%b ctrl=%b addr=%h: got err=%b rd=%h lat=%0d want err=%b rd=%h lat=%0d",
                                it, we, ctrl, addr, err, rd, lat, exp_err, exp_rd, exp_lat);
            end
            total++;
            if (log_addr.size() != n) begin
                bad++; $display("FAIL random_count[%0d]: got %0d bytes want %0d", it, log_addr.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    a = addr + i;
                    total++;
                    if ({log_addr[i], log_we[i], log_wd[i]} !== {a, we, wdata[8*i +: 8]}) begin
                        bad++; $display("FAIL random_bus[%0d.%0d]: got a=%h we=%b d=%h want a=%h we=%b d=%h",
                                        it, i, log_addr[i], log_we[i], log_wd[i], a, we, wdata[8*i +: 8]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int lat; logic [31:0] rd; logic err, rr, ra, va;
        logic [31:0] exp_rd; logic exp_err; int n;
        bit seen;
        for (int i = 0; i < 8; i++) mem[12'h400 + i] = 8'($urandom_range(1, 255));
        run_req(1'b0, 3'b010, 32'h400, 32'h0, lat, rd, err, rr, ra, va);
        waits = '{0, 0, 3};
        @(negedge clk);
        req_valid = 1'b1; DMWr = 1'b0; DMCtrl = 3'b010; Addr = 32'h400; WrData = 32'h5A5A5A5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h402) begin
            bad++; $display("FAIL midflight_pos: got req=%b addr=%h want 1 402", mem_req, mem_addr);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({rsp_valid, rsp_err, mem_req, mem_we, mem_addr, mem_wdata, RdData} !== '0) begin
            bad++; $display("FAIL midflight_async: got rv=%b mr=%b mw=%b ma=%h md=%h rd=%h want all 0",
                            rsp_valid, mem_req, mem_we, mem_addr, mem_wdata, RdData);
        end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        waits.delete();
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        total++;
        if (seen || req_ready !== 1'b1) begin
            bad++; $display("FAIL midflight_norsp: got rsp_seen=%b ready=%b want 0 1", seen, req_ready);
        end
        model(1'b0, 3'b010, 32'h404, exp_err, exp_rd, n);
        run_req(1'b0, 3'b010, 32'h404, 32'h0, lat, rd, err, rr, ra, va);
        total++;
        if (rd !== exp_rd || err !== 1'b0 || lat != 5) begin
            bad++; $display("FAIL midflight_next: got rd=%h err=%b lat=%0d want %h 0 5", rd, err, lat, exp_rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        test_reset();
        test_byte_load();
        test_word_load();
        test_store_waits();
        test_errors();
        test_timeout();
        test_random();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_byte_sequencer.md
Name: dm_byte_sequencer

Overview:
- Executes one data-memory access per request, using the decoded memory controls DMWr and DMCtrl (RISC-V funct3 encoding) produced by instruction decode.
- Drives a byte-wide memory bus and serialises each access into 1, 2 or 4 little-endian byte transactions.
- Assembles load data with sign or zero extension and returns one response per request.
- Sits between the MEM pipeline stage and the data memory. The pipeline stalls while req_ready is low.

Parameters:
- ADDR_W, 32, width of the byte address.
- TIMEOUT, 16, maximum number of cycles to wait for mem_ack on one byte; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active high.
- req_valid  in  1  the pipeline presents an access.
- req_ready  out  1  high only in IDLE.
- DMWr  in  1  1 = store, 0 = load.
- DMCtrl  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- Addr  in  ADDR_W  byte address.
- WrData  in  32  store data.
- rsp_valid  out  1  one-cycle pulse marking completion.
- rsp_err  out  1  qualifies rsp_valid: misaligned, illegal or timeout.
- RdData  out  32  load result, held until the next response.
- mem_req  out  1  byte transaction request.
- mem_we  out  1  byte write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_ack  in  1  sampled on the edge while mem_req = 1.
- mem_rdata  in  8  valid when mem_ack = 1.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; rsp_valid, rsp_err, mem_req and mem_we = 0; RdData, mem_addr and mem_wdata = 0; byte and wait counters = 0. An in-flight bus transaction is abandoned and no response is produced.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch DMWr, DMCtrl, Addr and WrData, and set byte count n: 1 for b/bu, 2 for h/hu, 4 for w.
  - Illegal request: DMCtrl in {011, 110, 111}, or a store with DMCtrl[2] = 1.
  - Misaligned request: n = 2 with Addr[0] = 1, or n = 4 with Addr[1:0] ≠ 0.
  - Illegal or misaligned: go to RESP with the error flag set; no mem_req is issued. Otherwise go to ACCESS with k = 0.
- ACCESS:
  - Outputs: mem_req = 1, mem_addr = Addr + k (modulo 2^ADDR_W), mem_we = DMWr, mem_wdata = WrData[8k+7:8k].
  - These outputs stay stable until mem_ack is sampled.
  - On mem_ack:
    - For a load, store mem_rdata into byte k of the internal buffer.
    - The wait counter clears.
    - If k = n-1, go to RESP. Otherwise k increments and the next byte's request starts in the following cycle; mem_req stays high.
  - Without mem_ack, the wait counter increments. When TIMEOUT ≠ 0 and the counter reaches TIMEOUT, go to RESP with the error flag set.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE. req_ready = 0.
  - rsp_err = error flag; it is cleared when the FSM leaves RESP.
  - RdData is updated in this cycle:
    - Store or error: 0.
    - b: sign-extend bit 7.
    - bu: zero-extend the byte.
    - h: sign-extend bit 15.
    - hu: zero-extend the halfword.
    - w: all 32 bits.
- Latency: the request is accepted at edge 0 and the first mem_req is high in cycle 1. With zero-wait acks (ack in the same cycle as mem_req), rsp_valid is high in cycle n+1. Each wait cycle adds 1.
- A request arriving while req_ready = 0 is not accepted; the pipeline holds it.

Test Plan:
1. Memory byte 0x103 = 0x80. lb at Addr 0x103, then lbu at Addr 0x103 -> one mem_req each at address 0x103; RdData = 0xFFFFFF80, then 0x00000080; rsp_err = 0.
2. lw at Addr 0x200, bytes 11 22 33 44, zero-wait acks -> mem_addr sequence 0x200..0x203; rsp_valid in cycle 5; RdData = 0x44332211.
3. sw at Addr 0x300, WrData 0xA1B2C3D4, two wait cycles per byte -> writes D4, C3, B2, A1 to 0x300..0x303; rsp_valid in cycle 13; RdData = 0.
4. sh at Addr 0x201, then DMCtrl = 011 load at Addr 0x0 -> no mem_req; rsp_valid with rsp_err = 1 in cycle 1 for each; req_ready high again in cycle 2.
5. TIMEOUT = 4, lh at Addr 0x10, mem_ack never asserted -> mem_req held 4 cycles; rsp_err = 1; RdData = 0; FSM back in IDLE.
6. rst asserted during the 3rd byte of an lw -> outputs go to 0 immediately with no clock edge; no rsp_valid; the next lw completes normally.
